square_fall_sequencer: RTL and testbench
========================================

# square_fall_sequencer

Per-square animation sequencer directly upstream of the 8×8 square draw stage (`draw_control` + `draw_datapath`). On a spawn request it drives that stage through draw → wait-one-frame → erase → move cycles until the square reaches the bottom of the 160×120 screen. It supplies the base X, Y, colour and the `go` level the draw stage consumes. It raises `landed` when the square comes to rest.

## Interface
Parameters:
- `FRAME_TICKS`, default 833_333: clk cycles per animation frame (50 MHz / 60 Hz); the bench overrides it to a small value.
- `FALL_STEP`, default 1: rows moved per frame, range 1..7.
- `ERASE_COLOUR`, default 3'b000: colour used to erase the old position.

Ports:
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: reset, asynchronous, active-low.
- `spawn`  in  1: one-cycle request to start a square; honoured only in IDLE.
- `spawn_x`  in  8: left column of the new square.
- `spawn_colour`  in  3: colour of the new square.
- `enable`  in  1: when low, frame counting freezes.
- `X`  out  8: base column for the draw stage.
- `Y`  out  7: base row for the draw stage.
- `colour`  out  3: colour for the current phase.
- `go`  out  1: draw-stage enable, high for exactly 64 consecutive cycles per phase.
- `busy`  out  1: high in every state except IDLE.
- `landed`  out  1: one-cycle pulse when the square stops at the bottom.

## Operation
- FSM states: IDLE, DRAW, WAIT, ERASE, MOVE, LAND.
- IDLE:
  - On `spawn`: latch `X = min(spawn_x, 152)`, `Y = 0`, `sq_colour = spawn_colour`, then go to DRAW.
  - `spawn` in any other state is ignored and not queued.
- DRAW: `colour = sq_colour`, `go = 1` for 64 cycles. Then go to LAND if `Y == 112`, otherwise go to WAIT.
- WAIT:
  - `go = 0`. The frame counter increments only while `enable = 1`.
  - When the counter reaches `FRAME_TICKS-1` with `enable = 1`, clear it and go to ERASE.
- ERASE: `colour = ERASE_COLOUR`, `go = 1` for 64 cycles, X/Y unchanged, then go to MOVE.
- MOVE: one cycle with `go = 0`. `Y = min(Y + FALL_STEP, 112)`, computed at 8 bits to avoid 7-bit wrap. Then go to DRAW.
- LAND: one cycle with `landed = 1`, then go to IDLE. The square stays drawn, and X/Y/colour hold their last values.
- Phase counter:
  - 6 bits, counts 0..63 while `go` is high; the phase ends when it reaches 63.
  - `go` drops for at least one cycle between consecutive phases, so the downstream offset counter restarts at 0.
- X, Y and colour are stable for the whole 64-cycle phase and for one cycle after `go` falls, covering the draw stage's output register.

## Timing
- Reset values, all asserted asynchronously: state IDLE; `X = 0`, `Y = 0`, `colour = 0`, `go = 0`, `busy = 0`, `landed = 0`; phase and frame counters 0.
- `spawn` sampled at edge t: `busy` and `go` go high at t+1, and `go` stays high for cycles t+1..t+64.
- DRAW to WAIT: `go` low from t+65.
- WAIT lasts exactly `FRAME_TICKS` cycles when `enable` is held high. Each cycle with `enable` low extends it by one.
- ERASE is 64 cycles, MOVE is 1 cycle, then the next DRAW starts.
- Full frame iteration: 64 + `FRAME_TICKS` + 64 + 1 cycles.
- `landed` is high for the cycle after the final DRAW ends; `busy` falls the cycle after that.
- Reset mid-phase: `go` drops immediately and no further pixels are requested. A partially drawn square is left on screen; clearing the screen is the system's responsibility.
- `enable` has no effect during DRAW, ERASE, MOVE or LAND; phases always complete.

## Structure
- Shared package `meatsquare_pkg` holds:
  - `SQUARE_SIZE = 8`, `SCREEN_W = 160`, `SCREEN_H = 120`.
  - `MAX_X = 152`, `MAX_Y = 112`, `COLOUR_BLACK = 3'b000`.
  - The `fall_state_t` state encoding.
- One sub-module, `pixel_phase_timer`:
  - Inputs: `start`, `clk`, `resetn`.
  - Outputs: `go` (held for 64 cycles) and a one-cycle `done` on the last cycle.
  - Reused later by the background-clear block.

## Test plan
- Reset then spawn: with `FRAME_TICKS=4`, `spawn_x=40`, `spawn_colour=3'b100` → `go` high for exactly 64 cycles, `X=40`, `Y=0`, `colour=4`; then `go` low for 4 cycles; then 64 cycles of `colour=0` at `Y=0`; then 1 idle cycle; then a draw at `Y=1`.
- Clamp: `spawn_x=200` → `X=152`. With `FALL_STEP=5` starting from `Y=110`, the next DRAW is at `Y=112`, followed by a `landed` pulse and `busy=0` two cycles after DRAW ends.
- Spawn while busy: `spawn` with `spawn_x=10` during WAIT → X, Y and sequence unaffected. After LAND, a new spawn is accepted.
- Enable freeze: drop `enable` for 10 cycles in WAIT → ERASE starts 10 cycles later than the nominal 4 cycles; `go` stays low throughout.
- Reset mid-ERASE: assert `resetn=0` at phase count 30 → `go`, `busy`, X, Y and `colour` are 0 in the same cycle. After release, the block is in IDLE and a spawn restarts at `Y=0`.
- Full fall: `FALL_STEP=1`, `FRAME_TICKS=2` → 113 DRAW phases and 112 ERASE phases, with exactly one `landed` pulse.

Source files
------------

// File: rtl/meatsquare_pkg.sv
// rtl/meatsquare_pkg.sv - shared screen geometry, colours and fall-sequencer state encoding
package meatsquare_pkg;

  localparam int SQUARE_SIZE  = 8;
  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int PHASE_CYCLES = SQUARE_SIZE * SQUARE_SIZE;

  localparam logic [7:0] MAX_X        = 8'(SCREEN_W - SQUARE_SIZE);
  localparam logic [6:0] MAX_Y        = 7'(SCREEN_H - SQUARE_SIZE);
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT,
    ST_ERASE,
    ST_MOVE,
    ST_LAND
  } fall_state_t;

  // Sum is formed at 8 bits so a step near the bottom cannot wrap past row 127.
  function automatic logic [6:0] step_y(input logic [6:0] y, input int step);
    logic [7:0] sum;
    sum = {1'b0, y} + 8'(step);
    return (sum > {1'b0, MAX_Y}) ? MAX_Y : sum[6:0];
  endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// rtl/pixel_phase_timer.sv - holds go for one 64-pixel phase and flags its last cycle
module pixel_phase_timer
  import meatsquare_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic start,
  output logic go,
  output logic done
);

  logic [5:0] count;
  logic       active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      count  <= 6'd0;
    end else if (start) begin
      active <= 1'b1;
      count  <= 6'd0;
    end else if (active) begin
      if (count == 6'(PHASE_CYCLES - 1)) begin
        active <= 1'b0;
        count  <= 6'd0;
      end else begin
        count <= count + 6'd1;
      end
    end
  end

  assign go   = active;
  assign done = active && (count == 6'(PHASE_CYCLES - 1));

endmodule

// File: rtl/square_fall_sequencer.sv
// rtl/square_fall_sequencer.sv - drives the 8x8 draw stage through draw/wait/erase/move until the square lands
module square_fall_sequencer
  import meatsquare_pkg::*;
#(
  parameter int         FRAME_TICKS  = 833_333,
  parameter int         FALL_STEP    = 1,
  parameter logic [2:0] ERASE_COLOUR = COLOUR_BLACK
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spawn,
  input  logic [7:0] spawn_x,
  input  logic [2:0] spawn_colour,
  input  logic       enable,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [2:0] colour,
  output logic       go,
  output logic       busy,
  output logic       landed
);

  localparam int             FW         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAME_TICKS - 1);

  fall_state_t   state, state_nx;
  logic [FW-1:0] frame_cnt;
  logic [2:0]    sq_colour;
  logic          phase_start;
  logic          phase_done;
  logic          frame_end;

  assign frame_end = (state == ST_WAIT) && enable && (frame_cnt == FRAME_LAST);

  pixel_phase_timer u_phase_timer (
    .clk    (clk),
    .resetn (resetn),
    .start  (phase_start),
    .go     (go),
    .done   (phase_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // The timer is started on the edge that enters DRAW/ERASE so go rises with the state.
  always_comb begin
    state_nx    = state;
    phase_start = 1'b0;
    busy        = (state != ST_IDLE);
    landed      = (state == ST_LAND);
    case (state)
      ST_IDLE: begin
        if (spawn) begin
          state_nx    = ST_DRAW;
          phase_start = 1'b1;
        end
      end
      ST_DRAW: begin
        if (phase_done) state_nx = (Y == MAX_Y) ? ST_LAND : ST_WAIT;
      end
      ST_WAIT: begin
        if (frame_end) begin
          state_nx    = ST_ERASE;
          phase_start = 1'b1;
        end
      end
      ST_ERASE: begin
        if (phase_done) state_nx = ST_MOVE;
      end
      ST_MOVE: begin
        state_nx    = ST_DRAW;
        phase_start = 1'b1;
      end
      ST_LAND: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // X/Y/colour only change on edges where go is low, keeping them stable across each phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      X         <= 8'd0;
      Y         <= 7'd0;
      colour    <= 3'd0;
      sq_colour <= 3'd0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (spawn) begin
            X         <= (spawn_x > MAX_X) ? MAX_X : spawn_x;
            Y         <= 7'd0;
            sq_colour <= spawn_colour;
            colour    <= spawn_colour;
          end
        end
        ST_WAIT: begin
          if (frame_end) begin
            frame_cnt <= '0;
            colour    <= ERASE_COLOUR;
          end else if (enable) begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end
        ST_MOVE: begin
          Y      <= step_y(Y, FALL_STEP);
          colour <= sq_colour;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_fall_sequencer.sv
// tb/tb_square_fall_sequencer.sv - randomized scoreboard bench for square_fall_sequencer
module tb_square_fall_sequencer;

  localparam int         FT   = 4;
  localparam int         STEP = 5;
  localparam logic [2:0] EC   = 3'b000;

  logic       clk;
  logic       resetn;
  logic       spawn;
  logic [7:0] spawn_x;
  logic [2:0] spawn_colour;
  logic       enable;
  logic [7:0] X;
  logic [6:0] Y;
  logic [2:0] colour;
  logic       go;
  logic       busy;
  logic       landed;

  square_fall_sequencer #(
    .FRAME_TICKS  (FT),
    .FALL_STEP    (STEP),
    .ERASE_COLOUR (EC)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .spawn        (spawn),
    .spawn_x      (spawn_x),
    .spawn_colour (spawn_colour),
    .enable       (enable),
    .X            (X),
    .Y            (Y),
    .colour       (colour),
    .go           (go),
    .busy         (busy),
    .landed       (landed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit erase;
    int x;
    int y;
    int c;
    bit last;
    int start;
  } item_t;

  item_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int exp_landed = 0;
  int seen_landed = 0;
  int en_mode = 0;
  int phase_starts = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: the square visits rows 0, STEP, 2*STEP ... clamped at 112; every row but the last is erased.
  task automatic push_fall(input int sx, input int c, input int spawn_cyc);
    item_t it;
    int y;
    y = 0;
    while (1) begin
      it.erase = 0;
      it.x     = (sx > 152) ? 152 : sx;
      it.y     = y;
      it.c     = c;
      it.last  = (y == 112);
      it.start = (y == 0) ? spawn_cyc + 1 : -1;
      exp_q.push_back(it);
      if (y == 112) break;
      it.erase = 1;
      it.c     = EC;
      it.last  = 0;
      it.start = -1;
      exp_q.push_back(it);
      y = (y + STEP > 112) ? 112 : y + STEP;
    end
    exp_landed++;
  endtask

  task automatic do_spawn(input int sx, input int c);
    @(posedge clk);
    #1;
    spawn        = 1'b1;
    spawn_x      = 8'(sx);
    spawn_colour = 3'(c);
    push_fall(sx, c, cyc);
    @(posedge clk);
    #1;
    spawn = 1'b0;
  endtask

  task automatic wait_landed();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!landed && n < 20000);
    if (!landed) fail_now("landed_timeout");
    @(posedge clk);
  endtask

  initial begin
    int burst;
    burst  = 0;
    enable = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (en_mode == 0) enable = 1'b1;
      else if (burst > 0) begin
        enable = 1'b0;
        burst--;
      end else if ($urandom_range(0, 29) == 0) begin
        enable = 1'b0;
        burst  = 9;
      end else enable = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops one expectation per go rising edge and checks the phase shape and the gaps.
  bit    in_ph = 0;
  bit    pend_busy = 0;
  bit    unstable;
  item_t cur;
  int    len, gap, lows, cx, cy, cc;

  always @(negedge clk) begin
    if (!resetn) begin
      in_ph     = 0;
      pend_busy = 0;
      gap       = 0;
      lows      = 0;
    end else begin
      if (landed) seen_landed++;
      if (pend_busy) begin
        check("busy_after_land", busy, 0);
        pend_busy = 0;
      end
      if (go) begin
        if (!in_ph) begin
          phase_starts++;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_phase");
            cur.erase = 1;
            cur.last  = 0;
          end else begin
            cur = exp_q.pop_front();
            check(cur.erase ? "erase_x" : "draw_x", X, cur.x);
            check(cur.erase ? "erase_y" : "draw_y", Y, cur.y);
            check(cur.erase ? "erase_colour" : "draw_colour", colour, cur.c);
            check("busy_in_phase", busy, 1);
            if (cur.start >= 0) check("spawn_latency", cyc, cur.start);
            else if (cur.erase) check("wait_len", gap, FT + lows);
            else check("move_gap", gap, 1);
          end
          in_ph    = 1;
          len      = 1;
          unstable = 0;
          cx       = X;
          cy       = Y;
          cc       = colour;
        end else begin
          len++;
          if (X != cx || Y != cy || colour != cc) unstable = 1;
        end
      end else begin
        if (in_ph) begin
          in_ph = 0;
          if (X != cx || Y != cy || colour != cc) unstable = 1;
          check("phase_len", len, 64);
          check("phase_stable", unstable, 0);
          if (!cur.erase && cur.last) begin
            check("landed_pulse", landed, 1);
            pend_busy = 1;
          end
          gap  = 1;
          lows = enable ? 0 : 1;
        end else begin
          gap++;
          lows += enable ? 0 : 1;
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    spawn        = 1'b0;
    spawn_x      = 8'd0;
    spawn_colour = 3'd0;
    resetn       = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_landed", landed, 0);
    check("rst_x", X, 0);
    check("rst_y", Y, 0);
    check("rst_colour", colour, 0);
    resetn = 1'b1;

    en_mode = 0;
    do_spawn(40, 3'b100);
    wait_landed();

    en_mode = 1;
    do_spawn(200, $urandom_range(1, 7));
    repeat ($urandom_range(70, 1500)) @(posedge clk);
    #1;
    spawn        = 1'b1;
    spawn_x      = 8'd10;
    spawn_colour = 3'b111;
    @(posedge clk);
    #1;
    spawn = 1'b0;
    wait_landed();

    for (int i = 0; i < 2; i++) begin
      do_spawn($urandom_range(0, 255), $urandom_range(0, 7));
      wait_landed();
    end

    en_mode = 0;
    base    = phase_starts;
    do_spawn(77, 3'b010);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (phase_starts < base + 2 && n < 1000);
    if (phase_starts < base + 2) fail_now("erase_start_timeout");
    repeat (30) @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    exp_landed--;
    #1;
    check("midrst_go", go, 0);
    check("midrst_busy", busy, 0);
    check("midrst_x", X, 0);
    check("midrst_y", Y, 0);
    check("midrst_colour", colour, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    en_mode = 1;
    do_spawn($urandom_range(0, 255), $urandom_range(0, 7));
    wait_landed();
    repeat (3) @(posedge clk);

    check("queue_empty", exp_q.size(), 0);
    check("landed_count", seen_landed, exp_landed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
